alu_iter_unit: RTL

- WIDTH-bit registered ALU for the MIPS datapath. Replaces the 1-bit slice chain.
- Decodes the same R-type funct codes: AND, OR, ADD, SUB, SLT.
- Adds an iterative unsigned shift-add multiplier (MULTU) with internal HI/LO registers, readable with MFHI/MFLO.
- Uses a start/done handshake so the controller stalls during a multiply.

---
 rtl/alu_iter_if.sv | 34 +++
 rtl/alu_iter_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// Start/done handshake and operand/result bus for alu_iter_unit.
// ALU_OVERFLOW_EN adds the registered signed-overflow flag.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             carryOut;
  logic             zero;
  logic             busy;
  logic             done;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, Signal, dataA, dataB,
`ifdef ALU_OVERFLOW_EN
    input  ovf,
`endif
    input  dataOut, carryOut, zero, busy, done
  );

  modport slave (
    input  start, Signal, dataA, dataB,
`ifdef ALU_OVERFLOW_EN
    output ovf,
`endif
    output dataOut, carryOut, zero, busy, done
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Registered ALU with iterative shift-add MULTU and HI/LO registers.
// Optional macro ALU_OVERFLOW_EN enables the ovf output.
module alu_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  alu_iter_if.slave bus
);
  localparam int M = WIDTH - 1;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] whi_q, whi_d, wlo_q, wlo_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_s, sub_s, step_s;
  logic             sub_ov, slt;

  assign add_s  = {1'b0, bus.dataA} + {1'b0, bus.dataB};
  assign sub_s  = {1'b0, bus.dataA} + {1'b0, ~bus.dataB}
                + (WIDTH+1)'(1);
  assign sub_ov = (bus.dataA[M] != bus.dataB[M])
               && (sub_s[M] != bus.dataA[M]);
  // Sign of A-B corrected by overflow gives a true signed compare
  assign slt    = sub_s[M] ^ sub_ov;
  assign step_s = {1'b0, whi_q}
                + (wlo_q[0] ? {1'b0, mc_q} : '0);

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic add_ov;
  assign add_ov = (bus.dataA[M] == bus.dataB[M])
               && (add_s[M] != bus.dataA[M]);
  assign bus.ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    mc_d    = mc_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.Signal == F_MULTU) begin
          state_d = MUL;
          cnt_d   = '0;
          wlo_d   = bus.dataB;
          whi_d   = '0;
          mc_d    = bus.dataA;
        end else if (bus.start) begin
          dout_d = '0;
          cout_d = 1'b0;
          done_d = 1'b1;
`ifdef ALU_OVERFLOW_EN
          ovf_d  = 1'b0;
`endif
          unique case (1'b1)
            (bus.Signal == F_AND): dout_d = bus.dataA & bus.dataB;
            (bus.Signal == F_OR):  dout_d = bus.dataA | bus.dataB;
            (bus.Signal == F_ADD): begin
              dout_d = add_s[M:0];
              cout_d = add_s[WIDTH];
`ifdef ALU_OVERFLOW_EN
              ovf_d  = add_ov;
`endif
            end
            (bus.Signal == F_SUB): begin
              dout_d = sub_s[M:0];
              cout_d = sub_s[WIDTH];
`ifdef ALU_OVERFLOW_EN
              ovf_d  = sub_ov;
`endif
            end
            (bus.Signal == F_SLT):  dout_d = {{M{1'b0}}, slt};
            (bus.Signal == F_MFHI): dout_d = hi_q;
            (bus.Signal == F_MFLO): dout_d = lo_q;
            default: ;
          endcase
          zero_d = (dout_d == '0);
        end
      end
      MUL: begin
        whi_d = step_s[WIDTH:1];
        wlo_d = {step_s[0], wlo_q[M:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = step_s[WIDTH:1];
          lo_d    = {step_s[0], wlo_q[M:1]};
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      mc_q    <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      mc_q    <= mc_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.dataOut  = dout_q;
  assign bus.carryOut = cout_q;
  assign bus.zero     = zero_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == MUL);
endmodule
